// File: rtl/uart_rx_axis_fifo.sv
// UART receiver (8 data bits, optional even parity, 1 stop) feeding a
// first-word-fall-through FIFO exposed as an AXI-Stream master.
module uart_rx_axis_fifo #(
   parameter int CLK_RATE  = 50000000,
   parameter int BAUD      = 115200,
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int PARITY_EN = 1,
   parameter logic [WIDTH-1:0] LAST_CHAR = WIDTH'(8'h0A)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             uart_rx,
   output logic [WIDTH-1:0] m_axis_data,
   output logic             m_axis_valid,
   input  logic             m_axis_ready,
   output logic             m_axis_last,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overflow
);
   localparam int BAUD_DIV = CLK_RATE / BAUD;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(WIDTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] BAUD_END = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(HALF_DIV - 1);
   localparam logic [BW-1:0] BIT_END  = BW'(WIDTH - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t state_q, state_d;
   logic sync_q, rx_s_q, rx_prev_q;
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic par_q, par_d;
   logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
   logic [WIDTH:0] mem_q [DEPTH];
   logic [WIDTH:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic push, pop, full, baud_end;

   assign full     = (count_q == FULL_CNT);
   assign pop      = (count_q != '0) && m_axis_ready;
   assign baud_end = (baud_cnt_q == BAUD_END);

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      ovf_d      = 1'b0;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rx_prev_q && !rx_s_q) state_d = START;
         end
         START: begin
            if (baud_cnt_q == HALF_END) begin
               baud_cnt_d = '0;
               state_d    = rx_s_q ? IDLE : DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               shift_d    = {rx_s_q, shift_q[WIDTH-1:1]};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_END)
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               par_d      = rx_s_q;
               state_d    = STOP;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               state_d    = IDLE;
               // exactly one outcome per frame, in priority order
               if (!rx_s_q) ferr_d = 1'b1;
               else if ((PARITY_EN != 0) && ((^shift_q) != par_q))
                  perr_d = 1'b1;
               else if (full) ovf_d = 1'b1;
               else push = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {shift_q == LAST_CHAR, shift_q};
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_prev_q  <= 1'b1;
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sync_q     <= uart_rx;
         rx_s_q     <= sync_q;
         rx_prev_q  <= rx_s_q;
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end

   assign m_axis_data  = mem_q[rd_ptr_q][WIDTH-1:0];
   assign m_axis_last  = mem_q[rd_ptr_q][WIDTH];
   assign m_axis_valid = (count_q != '0);
   assign parity_err   = perr_q;
   assign frame_err    = ferr_q;
   assign overflow     = ovf_q;

endmodule
